tl_cntr_multi: RTL and testbench

Parametrised multi-approach traffic-light controller with left-turn phases: the successor to the two-road, three-bit-state left-turn controller. It serves N_DIR approaches in round-robin order, and each approach runs green, yellow, left-turn and yellow phases. Phase durations come from an internal cycle timer instead of an external tick. It sits directly behind the intersection sensor inputs and drives every approach's lamp code.

---
 rtl/tl_cntr_multi.sv | 149 ++++++++++++++
 tb/tb_tl_cntr_multi.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tl_cntr_multi.sv
// Round-robin multi-approach traffic-light controller with left-turn phases and an internal phase timer.
// Optional emergency all-red preemption is built when TL_EMERG_EN is defined.
module tl_lamp_dec (
  input  logic       act_i,
  input  logic [2:0] phase_i,
  output logic [1:0] code_o
);
  always_comb begin
    code_o = 2'b11;
    if (act_i) begin
      case (phase_i)
        3'd0:             code_o = 2'b00;
        3'd1, 3'd3, 3'd4: code_o = 2'b01;
        3'd2:             code_o = 2'b10;
        default:          code_o = 2'b11;
      endcase
    end
  end
endmodule

module tl_cntr_multi #(
  parameter int N_DIR     = 2,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YEL_CYC   = 2,
  parameter int LEFT_CYC  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DIR-1:0]   T,
`ifdef TL_EMERG_EN
  input  logic               emerg,
`endif
  output logic [2*N_DIR-1:0] L,
  output logic [2:0]         dir,
  output logic [2:0]         phase
);
  typedef enum logic [2:0] {
    S_GRN  = 3'd0,
    S_Y1   = 3'd1,
    S_LFT  = 3'd2,
    S_Y2   = 3'd3,
    S_EY   = 3'd4,
    S_ARED = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] GMIN_M1  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] LEFT_M1  = CNT_W'(LEFT_CYC - 1);
  localparam logic [2:0]       DIR_LAST = 3'(N_DIR - 1);

  state_e           state_q, state_d;
  logic [2:0]       dir_q, dir_d, dir_adv;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             pend_q, pend_d;
  logic             emg;
  logic [7:0]       t_pad;
  logic             t_act;

`ifdef TL_EMERG_EN
  assign emg = emerg;
`else
  assign emg = 1'b0;
`endif

  // Pad so any 3-bit dir index is in range regardless of N_DIR.
  assign t_pad   = 8'(T);
  assign t_act   = t_pad[dir_q];
  assign dir_adv = (dir_q == DIR_LAST) ? 3'd0 : dir_q + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_GRN;
      dir_q   <= 3'd0;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tmr_d   = tmr_q;
    pend_d  = 1'b0;
    case (state_q)
      S_GRN: begin
        if (emg) state_d = S_EY;
        else if (tmr_q >= GMIN_M1 && (!t_act || tmr_q == GMAX_M1)) state_d = S_Y1;
      end
      // A request seen anywhere in a yellow is remembered until that yellow ends.
      S_Y1: begin
        pend_d = pend_q | emg;
        if (tmr_q == YEL_M1) state_d = (pend_q | emg) ? S_ARED : S_LFT;
      end
      S_LFT: begin
        if (emg) state_d = S_EY;
        else if (tmr_q == LEFT_M1) state_d = S_Y2;
      end
      S_Y2: begin
        pend_d = pend_q | emg;
        if (tmr_q == YEL_M1) begin
          if (pend_q | emg) state_d = S_ARED;
          else begin
            state_d = S_GRN;
            dir_d   = dir_adv;
          end
        end
      end
      S_EY: begin
        if (tmr_q == YEL_M1) state_d = S_ARED;
      end
      S_ARED: begin
        if (!emg && tmr_q >= YEL_M1) begin
          state_d = S_GRN;
          dir_d   = dir_adv;
        end
      end
      default: state_d = S_GRN;
    endcase
    // Saturation only matters for an all-red held open indefinitely.
    if (state_d != state_q) begin
      tmr_d  = '0;
      pend_d = 1'b0;
    end else if (tmr_q != '1) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  logic [N_DIR-1:0][1:0] lamp;

  for (genvar i = 0; i < N_DIR; i++) begin : g_lamp
    tl_lamp_dec u_dec (
      .act_i   (dir_q == 3'(i)),
      .phase_i (state_q),
      .code_o  (lamp[i])
    );
  end

  assign L     = lamp;
  assign dir   = dir_q;
  assign phase = state_q;
endmodule

// File: tb/tb_tl_cntr_multi.sv
// Scoreboard bench for tl_cntr_multi: per-cycle stimulus and expected lamp/dir/phase are queued, then replayed.
module tb_tl_cntr_multi;
  localparam int ND = 3, GMIN = 4, GMAX = 10, YEL = 2, LFT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] T = 3'b000;
`ifdef TL_EMERG_EN
  logic       emerg = 1'b0;
`endif
  logic [5:0] L;
  logic [2:0] dir, phase;

  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {
    logic [2:0] t;
    logic       em;
    logic [2:0] d;
    logic [2:0] ph;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  tl_cntr_multi #(
    .N_DIR(ND), .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YEL_CYC(YEL), .LEFT_CYC(LFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .T     (T),
`ifdef TL_EMERG_EN
    .emerg (emerg),
`endif
    .L     (L),
    .dir   (dir),
    .phase (phase)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [5:0] lamp_of(input logic [2:0] d, input logic [2:0] ph);
    logic [5:0] r;
    logic [1:0] c;
    r = '1;
    for (int i = 0; i < ND; i++) begin
      c = 2'b11;
      if (d == 3'(i)) begin
        case (ph)
          3'd0:             c = 2'b00;
          3'd1, 3'd3, 3'd4: c = 2'b01;
          3'd2:             c = 2'b10;
          default:          c = 2'b11;
        endcase
      end
      r[2*i +: 2] = c;
    end
    return r;
  endfunction

  task automatic push(input logic [2:0] t, input logic em, input logic [2:0] d,
                      input logic [2:0] ph, input int n);
    ent_t e;
    e.t = t; e.em = em; e.d = d; e.ph = ph;
    repeat (n) q.push_back(e);
  endtask

  task automatic push_svc(input logic [2:0] d, input int glen, input logic [2:0] t);
    push(t, 1'b0, d, 3'd0, glen);
    push(t, 1'b0, d, 3'd1, YEL);
    push(t, 1'b0, d, 3'd2, LFT);
    push(t, 1'b0, d, 3'd3, YEL);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    T = 3'b000;
`ifdef TL_EMERG_EN
    emerg = 1'b0;
`endif
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;
    chk({tag, "_rst_L"}, 32'(L), 32'h3c);
    chk({tag, "_rst_dir"}, 32'(dir), 32'd0);
    chk({tag, "_rst_ph"}, 32'(phase), 32'd0);
  endtask

  task automatic run(input string tag);
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      T = e.t;
`ifdef TL_EMERG_EN
      emerg = e.em;
`endif
      chk({tag, "_L"}, 32'(L), 32'(lamp_of(e.d, e.ph)));
      chk({tag, "_dir"}, 32'(dir), 32'(e.d));
      chk({tag, "_ph"}, 32'(phase), 32'(e.ph));
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    // Idle round: every approach gets minimum green, round wraps back to dir 0.
    do_reset("idle");
    for (int d = 0; d < ND; d++) push_svc(3'(d), GMIN, 3'b000);
    push(3'b000, 1'b0, 3'd0, 3'd0, 1);
    run("idle");

    // Traffic held on approach 0: green runs to the maximum.
    do_reset("hold");
    push_svc(3'd0, GMAX, 3'b001);
    push(3'b001, 1'b0, 3'd1, 3'd0, 2);
    run("hold");

    // Traffic drops at green timer 6: green lasts 7 cycles.
    do_reset("drop");
    push(3'b001, 1'b0, 3'd0, 3'd0, 6);
    push(3'b000, 1'b0, 3'd0, 3'd0, 1);
    push(3'b000, 1'b0, 3'd0, 3'd1, YEL);
    push(3'b000, 1'b0, 3'd0, 3'd2, 1);
    run("drop");

    // Traffic everywhere: every approach hits maximum green.
    do_reset("busy");
    for (int d = 0; d < ND; d++) push_svc(3'(d), GMAX, 3'b111);
    push(3'b111, 1'b0, 3'd0, 3'd0, 1);
    run("busy");

    // Reset during the left-turn phase of approach 2.
    do_reset("midrst");
    push_svc(3'd0, GMIN, 3'b000);
    push_svc(3'd1, GMIN, 3'b000);
    push(3'b000, 1'b0, 3'd2, 3'd0, GMIN);
    push(3'b000, 1'b0, 3'd2, 3'd1, YEL);
    push(3'b000, 1'b0, 3'd2, 3'd2, 1);
    run("midrst");
    do_reset("midrst_after");
    push(3'b000, 1'b0, 3'd0, 3'd0, 2);
    run("midrst_post");

`ifdef TL_EMERG_EN
    // One-cycle emergency pulse at green timer 1 of approach 1.
    do_reset("epulse");
    push_svc(3'd0, GMIN, 3'b000);
    push(3'b000, 1'b0, 3'd1, 3'd0, 1);
    push(3'b000, 1'b1, 3'd1, 3'd0, 1);
    push(3'b000, 1'b0, 3'd1, 3'd4, YEL);
    push(3'b000, 1'b0, 3'd1, 3'd5, YEL);
    push(3'b000, 1'b0, 3'd2, 3'd0, 2);
    run("epulse");

    // Emergency raised in the second yellow of approach 0 and held 5 cycles.
    do_reset("ey2");
    push(3'b000, 1'b0, 3'd0, 3'd0, GMIN);
    push(3'b000, 1'b0, 3'd0, 3'd1, YEL);
    push(3'b000, 1'b0, 3'd0, 3'd2, LFT);
    push(3'b000, 1'b1, 3'd0, 3'd3, YEL);
    push(3'b000, 1'b1, 3'd0, 3'd5, 3);
    push(3'b000, 1'b0, 3'd0, 3'd5, 1);
    push(3'b000, 1'b0, 3'd1, 3'd0, 2);
    run("ey2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
